// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for a multi-cycle RV32I core. It steps each instruction
// through fetch, decode, execute, memory and writeback states. From the current
// state it drives the mux selects and write enables for a shared memory, the
// ALU, the register file and the IR/OldPC/PC registers. It also traps illegal
// opcodes and counts retired instructions.
//
// Memory handshake: the FSM holds a memory request (FETCH, MEMREAD or MEMWRITE)
// for as many cycles as it takes. mem_ready=1 means the access completes in
// this cycle. The FSM advances only on that cycle, and any side effect tied to
// completion (IRWrite/PC update in FETCH, Retire in MEMWRITE) fires only on
// that cycle. MemWrite stays asserted on every MEMWRITE cycle up to and
// including the mem_ready cycle.
//
// Ports:
//   clk          system clock, rising-edge
//   rst          synchronous active-high reset
//   Op/funct3/funct7  instruction fields from the IR
//   Zero         ALU zero flag (branch condition)
//   mem_ready    memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath selects
//   Illegal      sticky trap flag, cleared only by rst
//   Retire       one-cycle pulse per completed instruction
//   RetireCount  retired-instruction count, wraps modulo 2^CNT_W
//   dbg_state    current FSM state, for observation only
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic             Retire,
  output logic [CNT_W-1:0] RetireCount,
  output logic [3:0]       dbg_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_retire_count;
  logic             r_illegal;

  // Raw (ungated) state decodes; the enables are masked by rst below.
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_retire;
  logic [1:0] w_alu_op;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_imm_src;
  logic [2:0] w_alu_control;

  // Only funct7[5] matters for the ALU decode (sub vs add).
  logic w_unused_funct7;
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_EXECUTER;
          OP_ITYP:      w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      // JAL writes PC+4 into rd through the common ALU writeback state.
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore on state, plus mem_ready qualification)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_alu_op     = 2'b00;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_imm_src    = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        // PC+4 is taken straight from the ALU (ResultSrc=10) so the PC and IR
        // update together on the cycle the fetch completes.
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target OldPC + B-imm into ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = 2'b10;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (Op == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_imm_src   = 2'b11;
        w_pc_update = 1'b1;
      end
      S_TRAP: begin
      end
      default: begin
      end
    endcase

    // ALU decoder
    w_alu_control = 3'b000;
    unique case (w_alu_op)
      2'b00: w_alu_control = 3'b000;
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        unique case (funct3)
          // Only register-register ops with funct7[5] subtract; addi never does.
          3'b000:  w_alu_control = (Op[5] & funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Retire counter and sticky trap flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_count <= '0;
      r_illegal      <= 1'b0;
    end else begin
      if (w_retire) r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (r_state == S_TRAP) r_illegal <= 1'b1;
    end
  end

  // Enables are masked during reset so an abandoned instruction never writes.
  assign PCWrite     = (w_pc_update | (w_branch & Zero)) & ~rst;
  assign MemWrite    = w_mem_write & ~rst;
  assign IRWrite     = w_ir_write & ~rst;
  assign RegWrite    = w_reg_write & ~rst;
  assign Retire      = w_retire & ~rst;
  assign AdrSrc      = w_adr_src;
  assign ResultSrc   = w_result_src;
  assign ALUSrcA     = w_alu_src_a;
  assign ALUSrcB     = w_alu_src_b;
  assign ImmSrc      = w_imm_src;
  assign ALUControl  = w_alu_control;
  assign Illegal     = r_illegal;
  assign RetireCount = r_retire_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_control_fsm (CNT_W = 4 so the counter wrap is short).
// The reference model works per instruction. From the instruction class and
// the chosen memory wait counts it predicts the latency, the number of each
// enable pulse, the ALU operation and the retired count.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_BEQ = 4;
  localparam int K_JAL = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       Op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ImmSrc;
  logic [2:0]       ALUControl;
  logic             Illegal;
  logic             Retire;
  logic [CNT_W-1:0] RetireCount;
  logic [3:0]       dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [CNT_W-1:0] exp_count;
  logic [CNT_W-1:0] exp_q[$];

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .Retire(Retire), .RetireCount(RetireCount), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] opcode_of(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  // Cycles per instruction with no memory wait states.
  function automatic int base_cycles(input int k);
    case (k)
      K_LW:    return 5;
      K_BEQ:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    case (f3)
      3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver + per-instruction checks. fw = wait cycles in fetch, mw = wait
  // cycles in the memory access (lw/sw only). Entered and left at the start
  // of a fetch cycle.
  // ---------------------------------------------------------------------------
  task automatic run_instr(input int k, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int fw, input int mw, input string name);
    bit         uses_mem;
    int         len, mem_at, exec_at;
    int         n_ret, ret_idx, n_rw, n_mw, n_ir, ir_idx, n_pc;
    int         exp_rw, exp_mw, exp_pc;
    logic [2:0] alu_seen, alu_exp;
    logic       pc_at_exec;
    logic [1:0] rsrc_last;
    logic [CNT_W-1:0] want;

    uses_mem = (k == K_LW) || (k == K_SW);
    len      = base_cycles(k) + fw + (uses_mem ? mw : 0);
    mem_at   = fw + 3;
    exec_at  = fw + 2;
    n_ret = 0; ret_idx = -1; n_rw = 0; n_mw = 0; n_ir = 0; ir_idx = -1; n_pc = 0;
    alu_seen = 3'bxxx; pc_at_exec = 1'bx; rsrc_last = 2'bxx;

    Op = opcode_of(k); funct3 = f3; funct7 = f7; Zero = z;
    for (int i = 0; i < len; i++) begin
      if (i < fw) mem_ready = 1'b0;
      else if (i == fw) mem_ready = 1'b1;
      else if (uses_mem && i >= mem_at && i < mem_at + mw) mem_ready = 1'b0;
      else if (uses_mem && i == mem_at + mw) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (Retire === 1'b1)   begin n_ret++; ret_idx = i; end
      if (RegWrite === 1'b1) n_rw++;
      if (MemWrite === 1'b1) n_mw++;
      if (IRWrite === 1'b1)  begin n_ir++; ir_idx = i; end
      if (PCWrite === 1'b1)  n_pc++;
      if (i == exec_at) begin alu_seen = ALUControl; pc_at_exec = PCWrite; end
      if (i == len - 1) rsrc_last = ResultSrc;
      tick();
    end

    exp_rw = (k == K_BEQ || k == K_SW) ? 0 : 1;
    exp_mw = (k == K_SW) ? mw + 1 : 0;
    exp_pc = 1 + ((k == K_JAL) ? 1 : 0) + ((k == K_BEQ && z) ? 1 : 0);
    exp_count = exp_count + 1'b1;
    exp_q.push_back(exp_count);

    n_assert++;
    if (n_ret !== 1 || ret_idx !== len - 1) begin
      n_fail++;
      $display("FAIL %s retire: pulses=%0d last_at=%0d, expected 1 pulse at cycle %0d",
               name, n_ret, ret_idx, len - 1);
    end
    n_assert++;
    if (n_rw !== exp_rw) begin
      n_fail++;
      $display("FAIL %s regwrite: cycles=%0d, expected %0d", name, n_rw, exp_rw);
    end
    n_assert++;
    if (n_mw !== exp_mw) begin
      n_fail++;
      $display("FAIL %s memwrite: cycles=%0d, expected %0d", name, n_mw, exp_mw);
    end
    n_assert++;
    if (n_ir !== 1 || ir_idx !== fw) begin
      n_fail++;
      $display("FAIL %s irwrite: pulses=%0d at=%0d, expected 1 at cycle %0d",
               name, n_ir, ir_idx, fw);
    end
    n_assert++;
    if (n_pc !== exp_pc) begin
      n_fail++;
      $display("FAIL %s pcwrite: cycles=%0d, expected %0d", name, n_pc, exp_pc);
    end
    if (k == K_R || k == K_I || k == K_BEQ) begin
      alu_exp = (k == K_BEQ) ? 3'b001 : exp_alu(opcode_of(k), f3, f7);
      n_assert++;
      if (alu_seen !== alu_exp) begin
        n_fail++;
        $display("FAIL %s alucontrol: got %b, expected %b", name, alu_seen, alu_exp);
      end
    end
    if (k == K_BEQ) begin
      n_assert++;
      if (pc_at_exec !== z) begin
        n_fail++;
        $display("FAIL %s beq_pcwrite: got %b, expected %b", name, pc_at_exec, z);
      end
    end
    if (k == K_LW) begin
      n_assert++;
      if (rsrc_last !== 2'b01) begin
        n_fail++;
        $display("FAIL %s memwb_resultsrc: got %b, expected 01", name, rsrc_last);
      end
    end
    want = exp_q.pop_front();
    n_assert++;
    if (RetireCount !== want || Illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL %s count: RetireCount=%0d Illegal=%b, expected %0d and 0",
               name, RetireCount, Illegal, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_count = '0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Power-on reset: enables low while rst is high.
    rst = 1'b1; mem_ready = 1'b1; Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0;
    Zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite, Retire} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_enables: got %b, expected 00000",
                 {PCWrite, MemWrite, IRWrite, RegWrite, Retire});
      end
      tick();
    end
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_assert++;
    if (RetireCount !== '0 || Illegal !== 1'b0 || IRWrite !== 1'b0 ||
        ResultSrc !== 2'b10 || ALUSrcB !== 2'b10 || AdrSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d ill=%b ir=%b rs=%b srcb=%b adr=%b, expected fetch with 0/0",
               RetireCount, Illegal, IRWrite, ResultSrc, ALUSrcB, AdrSrc);
    end
    tick();
    exp_count = '0;

    // One completed add, then reset in the middle of a second R-type.
    run_instr(K_R, 3'b000, 7'b0000000, 1'b0, 0, 0, "pre_reset_add");
    Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; mem_ready = 1'b1;
    tick();  // FETCH
    tick();  // DECODE -> now in EXECUTER
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite, Retire} !== 5'b0) begin
        n_fail++;
        $display("FAIL midreset_enables: got %b, expected 00000",
                 {PCWrite, MemWrite, IRWrite, RegWrite, Retire});
      end
      tick();
    end
    rst = 1'b0; mem_ready = 1'b0;
    exp_count = '0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++;
      if (RegWrite !== 1'b0 || Retire !== 1'b0 || RetireCount !== '0 ||
          ResultSrc !== 2'b10 || ALUSrcB !== 2'b10) begin
        n_fail++;
        $display("FAIL midreset_release: rw=%b ret=%b cnt=%0d rs=%b srcb=%b, expected fetch, no write, count 0",
                 RegWrite, Retire, RetireCount, ResultSrc, ALUSrcB);
      end
      tick();
    end
  endtask

  task automatic test_rtype_sub();
    run_instr(K_R, 3'b000, 7'b0100000, 1'b1, 0, 0, "rtype_sub");
  endtask

  task automatic test_lw_wait();
    run_instr(K_LW, 3'b010, 7'b0000000, 1'b0, 2, 1, "lw_wait");
  endtask

  task automatic test_beq();
    run_instr(K_BEQ, 3'b000, 7'b0000000, 1'b1, 0, 0, "beq_taken");
    run_instr(K_BEQ, 3'b000, 7'b0000000, 1'b0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_illegal();
    logic [4:0] en;
    Op = 7'b1111111; mem_ready = 1'b1;
    tick();  // FETCH
    @(negedge clk);
    n_assert++;
    if (Illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_early: Illegal=%b in decode, expected 0", Illegal);
    end
    tick();  // DECODE -> TRAP
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      Zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      en = {PCWrite, MemWrite, IRWrite, RegWrite, Retire};
      n_assert++;
      if (en !== 5'b0 || (i >= 1 && Illegal !== 1'b1)) begin
        n_fail++;
        $display("FAIL trap_hold cycle %0d: enables=%b Illegal=%b, expected 00000 and 1",
                 i, en, Illegal);
      end
      tick();
    end
    do_reset();
    @(negedge clk);
    n_assert++;
    if (Illegal !== 1'b0 || RetireCount !== '0) begin
      n_fail++;
      $display("FAIL trap_clear: Illegal=%b cnt=%0d, expected 0 and 0", Illegal, RetireCount);
    end
    tick();  // mem_ready=0 keeps the FSM in fetch
  endtask

  task automatic test_random();
    int         k, fw, mw;
    logic [2:0] f3;
    logic [6:0] f7;
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 5);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      run_instr(k, f3, f7, 1'($urandom_range(0, 1)), fw, mw, "random");
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int n = 0; n < 17; n++) begin
      run_instr(K_BEQ, 3'b000, 7'b0, 1'($urandom_range(0, 1)), 0, 0, "wrap_beq");
    end
    n_assert++;
    if (RetireCount !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_final: RetireCount=%0d, expected 1", RetireCount);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; Op = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; mem_ready = 1'b0;
    exp_count = '0;
    #1;
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_random();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and write enables for a shared memory, ALU, register file and IR/PC registers.
- Handles wait states on memory, traps illegal opcodes, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Op  input  7  opcode field from instruction register
funct3  input  3  funct3 field from instruction register
funct7  input  7  funct7 field from instruction register
Zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction/OldPC register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = Imm, 10 = constant 4
ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
Illegal  output  1  sticky trap flag
Retire  output  1  one-cycle pulse when an instruction completes
RetireCount  output  CNT_W  retired-instruction count

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- On rst at a rising edge: state <= FETCH, RetireCount <= 0, Illegal <= 0. While rst is high, all enables (PCWrite, MemWrite, IRWrite, RegWrite, Retire) are forced to 0. Reset mid-instruction abandons it with no partial write.
- Outputs are Moore decodes of the state, except:
  - PCWrite = PCUpdate | (Branch & Zero);
  - mem_ready gating as noted below.
- Unlisted selects are 00. Unlisted enables are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUOp=00 (branch target). Next state by Op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. ImmSrc=00 for lw, 01 for sw. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready. Then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUOp=10. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ImmSrc=11, ResultSrc=00, PCUpdate=1. Then ALUWB.
- TRAP: Illegal <= 1. All enables 0. Stay until rst.
- ALU decode:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3: 000 -> 001 if (Op[5] & funct7[5]), else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
- Retire pulses for one cycle in MEMWB, ALUWB, BEQ and in MEMWRITE when mem_ready=1. JAL retires in its ALUWB. RetireCount increments on the same edge and wraps modulo 2^CNT_W.
- Latencies with mem_ready constantly 1:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset:
  - Stimulus: rst high for 2 cycles mid-EXECUTER, then low.
  - Required: FETCH on the first cycle after release; RetireCount=0; no RegWrite pulse during or after reset for the abandoned instruction.
- R-type sub:
  - Stimulus: Op=0110011, funct3=000, funct7=0100000, mem_ready=1.
  - Required: state sequence FETCH, DECODE, EXECUTER, ALUWB; ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB; Retire pulses once.
- lw with wait states:
  - Stimulus: Op=0000011, mem_ready=0 for 2 cycles in FETCH and 1 cycle in MEMREAD.
  - Required: 8 total cycles; IRWrite=1 only on the mem_ready=1 FETCH cycle; ResultSrc=01 in MEMWB.
- beq taken and not taken:
  - Stimulus: Op=1100011 with Zero=1, then again with Zero=0.
  - Required: in the BEQ state, PCWrite=1 when Zero=1 and PCWrite=0 when Zero=0; ALUControl=001 in both cases.
- Illegal opcode:
  - Stimulus: Op=1111111.
  - Required: DECODE goes to TRAP; Illegal=1 held for 10 or more cycles with all enables 0; rst then clears Illegal.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 back-to-back beq instructions.
  - Required: RetireCount reads 15, then 0, then 1.
